// File: rtl/ai_pkg.sv
// ============================================================================
// Module : ai_pkg
// Brief  : Shared constants, register map and enums for the ai_core engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ai_pkg;

  localparam int BOARD_DIM  = 10;
  localparam int NUM_CELLS  = BOARD_DIM * BOARD_DIM;
  localparam int SCAN_LIMIT = 2 * NUM_CELLS;

  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_RESULT = 4'd1;
  localparam logic [3:0] ADDR_SHOT   = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;
  localparam logic [3:0] ADDR_SEED   = 4'd4;

  localparam logic [1:0] RES_MISS   = 2'd0;
  localparam logic [1:0] RES_HIT    = 2'd1;
  localparam logic [1:0] RES_SUNK   = 2'd2;
  localparam logic [1:0] RES_IGNORE = 2'd3;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEARCH} state_e;
  typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;

  function automatic logic [6:0] cell_index(input logic [3:0] x, input logic [3:0] y);
    return 7'(y) * 7'(BOARD_DIM) + 7'(x);
  endfunction

  function automatic logic [3:0] cell_x(input logic [6:0] idx);
    return 4'(idx % 7'(BOARD_DIM));
  endfunction

  function automatic logic [3:0] cell_y(input logic [6:0] idx);
    return 4'(idx / 7'(BOARD_DIM));
  endfunction

endpackage

`default_nettype wire

// File: rtl/ai_lfsr.sv
// ============================================================================
// Module : ai_lfsr
// Brief  : 7-bit Fibonacci LFSR (x^7 + x^6 + 1) with seed load and step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ai_lfsr (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [6:0] seed_i,
  input  logic       step_i,
  output logic [6:0] value_o
);

  logic [6:0] lfsr_q, lfsr_d;

  // An all-zero state would lock up, so a zero seed becomes 1.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == 7'd0) ? 7'd1 : seed_i;
    end else if (step_i) begin
      lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 7'd1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/ai_core.sv
// ============================================================================
// Module : ai_core
// Brief  : Memory-mapped battleship shot selector (10x10), parity hunt plus
//          neighbour targeting. Target mode is built only with AI_TARGET_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ai_core
  import ai_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  addr,
  input  logic        write_en,
  input  logic        read_en,
  input  logic [31:0] data_in,
  output logic        wait_request,
  output logic [31:0] data_out
);

  state_e      state_q, state_d;
  logic [6:0]  init_idx_q, init_idx_d;
  logic [99:0] board_q, board_d;
  logic        shot_valid_q, shot_valid_d;
  logic [3:0]  shot_x_q, shot_x_d, shot_y_q, shot_y_d;
  logic        mode_q, mode_d;
  logic        full_q, full_d;
  logic [6:0]  count_q, count_d;
  logic [3:0]  anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
  dir_e        dir_q, dir_d;
  logic [3:0]  cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [7:0]  scan_q, scan_d;

  logic        access, wr, ctrl_new, ctrl_start, seed_wr;
  logic [6:0]  lfsr_val, cursor;
  logic        nb_ok, nb_free, hunt_ok;
  logic [3:0]  nb_x, nb_y;
  logic [6:0]  nb_idx, hunt_idx;
  logic [31:0] rdata;
  logic        unused_bits;

  // Bus accesses only ever complete while idle; all other states stall them.
  assign access     = (state_q == ST_IDLE);
  assign wr         = access & write_en;
  assign ctrl_new   = wr && (addr == ADDR_CTRL) && data_in[1];
  assign ctrl_start = wr && (addr == ADDR_CTRL) && data_in[0] && !data_in[1];
  assign seed_wr    = wr && (addr == ADDR_SEED);
  assign unused_bits = ^data_in[31:7];

  ai_lfsr u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .load_i  (seed_wr),
    .seed_i  (data_in[6:0]),
    .step_i  (ctrl_start),
    .value_o (lfsr_val)
  );

  assign cursor = (lfsr_val >= 7'(NUM_CELLS)) ? lfsr_val - 7'(NUM_CELLS) : lfsr_val;

  always_comb begin
    nb_ok = 1'b0;
    nb_x  = anchor_x_q;
    nb_y  = anchor_y_q;
    case (dir_q)
      DIR_N: begin nb_ok = (anchor_y_q != 4'd0);              nb_y = anchor_y_q - 4'd1; end
      DIR_E: begin nb_ok = (anchor_x_q != 4'(BOARD_DIM - 1)); nb_x = anchor_x_q + 4'd1; end
      DIR_S: begin nb_ok = (anchor_y_q != 4'(BOARD_DIM - 1)); nb_y = anchor_y_q + 4'd1; end
      default: begin nb_ok = (anchor_x_q != 4'd0);            nb_x = anchor_x_q - 4'd1; end
    endcase
  end

  assign nb_idx   = cell_index(nb_x, nb_y);
  assign nb_free  = nb_ok && !board_q[nb_idx];
  assign hunt_idx = cell_index(cur_x_q, cur_y_q);
  // First 100 scanned cells are the parity pass; the second lap takes anything.
  assign hunt_ok  = !board_q[hunt_idx] &&
                    ((scan_q >= 8'(NUM_CELLS)) || !(cur_x_q[0] ^ cur_y_q[0]));

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    board_d      = board_q;
    shot_valid_d = shot_valid_q;
    shot_x_d     = shot_x_q;
    shot_y_d     = shot_y_q;
    mode_d       = mode_q;
    full_d       = full_q;
    count_d      = count_q;
    anchor_x_d   = anchor_x_q;
    anchor_y_d   = anchor_y_q;
    dir_d        = dir_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    scan_d       = scan_q;
    case (state_q)
      ST_INIT: begin
        board_d[init_idx_q] = 1'b0;
        if (init_idx_q == 7'(NUM_CELLS - 1)) begin
          state_d = ST_IDLE;
        end else begin
          init_idx_d = init_idx_q + 7'd1;
        end
      end
      ST_IDLE: begin
        if (ctrl_new) begin
          state_d      = ST_INIT;
          init_idx_d   = 7'd0;
          shot_valid_d = 1'b0;
          shot_x_d     = 4'd0;
          shot_y_d     = 4'd0;
          mode_d       = 1'b0;
          count_d      = 7'd0;
          full_d       = 1'b0;
        end else if (ctrl_start) begin
          shot_valid_d = 1'b0;
          cur_x_d      = cell_x(cursor);
          cur_y_d      = cell_y(cursor);
          scan_d       = 8'd0;
          dir_d        = DIR_N;
          state_d      = ST_SEARCH;
`ifdef AI_TARGET_EN
        end else if (wr && (addr == ADDR_RESULT)) begin
          if (data_in[1:0] == RES_HIT) begin
            anchor_x_d = shot_x_q;
            anchor_y_d = shot_y_q;
            mode_d     = 1'b1;
          end else if (data_in[1:0] == RES_SUNK) begin
            mode_d = 1'b0;
          end
`endif
        end
      end
      ST_SEARCH: begin
        if (mode_q) begin
          if (nb_free) begin
            board_d[nb_idx] = 1'b1;
            shot_valid_d    = 1'b1;
            shot_x_d        = nb_x;
            shot_y_d        = nb_y;
            count_d         = count_q + 7'd1;
            state_d         = ST_IDLE;
          end else begin
            if (dir_q == DIR_W) mode_d = 1'b0;
            dir_d = dir_e'(dir_q + 2'd1);
          end
        end else if (hunt_ok) begin
          board_d[hunt_idx] = 1'b1;
          shot_valid_d      = 1'b1;
          shot_x_d          = cur_x_q;
          shot_y_d          = cur_y_q;
          count_d           = count_q + 7'd1;
          state_d           = ST_IDLE;
        end else if (scan_q == 8'(SCAN_LIMIT - 1)) begin
          full_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          scan_d = scan_q + 8'd1;
          if (cur_x_q == 4'(BOARD_DIM - 1)) begin
            cur_x_d = 4'd0;
            cur_y_d = (cur_y_q == 4'(BOARD_DIM - 1)) ? 4'd0 : cur_y_q + 4'd1;
          end else begin
            cur_x_d = cur_x_q + 4'd1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      init_idx_q   <= 7'd0;
      board_q      <= '0;
      shot_valid_q <= 1'b0;
      shot_x_q     <= 4'd0;
      shot_y_q     <= 4'd0;
      mode_q       <= 1'b0;
      full_q       <= 1'b0;
      count_q      <= 7'd0;
      anchor_x_q   <= 4'd0;
      anchor_y_q   <= 4'd0;
      dir_q        <= DIR_N;
      cur_x_q      <= 4'd0;
      cur_y_q      <= 4'd0;
      scan_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      board_q      <= board_d;
      shot_valid_q <= shot_valid_d;
      shot_x_q     <= shot_x_d;
      shot_y_q     <= shot_y_d;
      mode_q       <= mode_d;
      full_q       <= full_d;
      count_q      <= count_d;
      anchor_x_q   <= anchor_x_d;
      anchor_y_q   <= anchor_y_d;
      dir_q        <= dir_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      scan_q       <= scan_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_SHOT:   rdata = {shot_valid_q, 19'd0, shot_y_q, 4'd0, shot_x_q};
      ADDR_STATUS: rdata = {17'd0, count_q, 5'd0, full_q, mode_q, (state_q != ST_IDLE)};
      default:     rdata = 32'd0;
    endcase
  end

  always_comb begin
    wait_request = 1'b0;
    case (state_q)
      ST_INIT:   wait_request = 1'b1;
      ST_SEARCH: wait_request = read_en | write_en;
      default:   wait_request = 1'b0;
    endcase
  end

  assign data_out = (read_en && !wait_request) ? rdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_ai_core.sv
// ============================================================================
// Module : tb_ai_core
// Brief  : Self-checking bench for ai_core: vector tables, directed sequences
//          and random traffic against a behavioural board model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ai_core;

  localparam logic [3:0] A_CTRL = 4'd0, A_RES = 4'd1, A_SHOT = 4'd2, A_STAT = 4'd3, A_SEED = 4'd4;
  localparam int BUDGET = 1000;
`ifdef AI_TARGET_EN
  localparam bit TGT = 1'b1;
`else
  localparam bit TGT = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic        write_en = 1'b0;
  logic        read_en = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic        wait_request;
  logic [31:0] data_out;

  int checks = 0;
  int failures = 0;

  ai_core dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .addr         (addr),
    .write_en     (write_en),
    .read_en      (read_en),
    .data_in      (data_in),
    .wait_request (wait_request),
    .data_out     (data_out)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit m_shot[100];
  int m_lfsr, m_mode, m_ax, m_ay, m_count, m_full, m_valid, m_sx, m_sy;

  function automatic int lfsr_next(input int v);
    return ((v * 2) % 128) + (((v / 64) ^ (v / 32)) % 2);
  endfunction

  task automatic model_newgame();
    for (int i = 0; i < 100; i++) m_shot[i] = 1'b0;
    m_mode = 0; m_count = 0; m_full = 0; m_valid = 0; m_sx = 0; m_sy = 0;
  endtask

  task automatic model_seed(input int v);
    m_lfsr = (v % 128 == 0) ? 1 : v % 128;
  endtask

  task automatic model_result(input int r);
    if (TGT && r == 1) begin
      m_ax = m_sx; m_ay = m_sy; m_mode = 1;
    end else if (TGT && r == 2) begin
      m_mode = 0;
    end
  endtask

  task automatic take(input int x, input int y);
    m_shot[y * 10 + x] = 1'b1;
    m_valid = 1; m_sx = x; m_sy = y; m_count++;
  endtask

  task automatic model_start();
    int cur, c;
    bit found;
    m_valid = 0;
    cur = (m_lfsr >= 100) ? m_lfsr - 100 : m_lfsr;
    m_lfsr = lfsr_next(m_lfsr);
    found = 1'b0;
    if (m_mode != 0) begin
      for (int d = 0; d < 4 && !found; d++) begin
        int nx, ny;
        nx = m_ax; ny = m_ay;
        case (d)
          0: ny = ny - 1;
          1: nx = nx + 1;
          2: ny = ny + 1;
          default: nx = nx - 1;
        endcase
        if (nx >= 0 && nx < 10 && ny >= 0 && ny < 10 && !m_shot[ny * 10 + nx]) begin
          take(nx, ny); found = 1'b1;
        end
      end
      if (!found) m_mode = 0;
    end
    for (int k = 0; k < 200 && !found; k++) begin
      c = (cur + k) % 100;
      if (!m_shot[c] && (k >= 100 || ((c % 10 + c / 10) % 2 == 0))) begin
        take(c % 10, c / 10); found = 1'b1;
      end
    end
    if (!found) m_full = 1;
  endtask

  function automatic logic [31:0] exp_shot();
    return {m_valid[0], 19'd0, 4'(m_sy), 4'd0, 4'(m_sx)};
  endfunction

  function automatic logic [31:0] exp_status();
    return {17'd0, 7'(m_count), 5'd0, m_full[0], m_mode[0], 1'b0};
  endfunction

  // ---------------- bus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int n;
    @(negedge clock);
    addr = a; data_in = d; write_en = 1'b1;
    n = 0;
    #1;
    while (wait_request && n < BUDGET) begin
      @(negedge clock); #1; n++;
    end
    if (n >= BUDGET) begin
      checks++; failures++;
      $display("FAIL write_timeout addr=%0d actual=stalled required=complete", a);
    end
    @(posedge clock); #1;
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output int stall);
    @(negedge clock);
    addr = a; read_en = 1'b1;
    stall = 0;
    #1;
    while (wait_request && stall < BUDGET) begin
      @(negedge clock); #1; stall++;
    end
    if (stall >= BUDGET) begin
      checks++; failures++;
      $display("FAIL read_timeout addr=%0d actual=stalled required=complete", a);
    end
    d = data_out;
    @(posedge clock); #1;
    read_en = 1'b0;
  endtask

  task automatic do_start_and_check(input string name);
    logic [31:0] d;
    int st;
    bus_write(A_CTRL, 32'd1);
    model_start();
    bus_read(A_SHOT, d, st);
    check(name, d, exp_shot());
  endtask

  task automatic new_game();
    bus_write(A_CTRL, 32'd2);
    model_newgame();
  endtask

  typedef struct { logic [3:0] a; logic [31:0] exp; } rd_vec_t;
  typedef struct { logic [31:0] seed; logic [31:0] shot; logic [31:0] status; } seed_vec_t;

  initial begin
    rd_vec_t     rd_tbl[6];
    seed_vec_t   seed_tbl[7];
    logic [31:0] d;
    int          st, n, r;

    rd_tbl[0] = '{A_CTRL, 32'd0};
    rd_tbl[1] = '{A_RES,  32'd0};
    rd_tbl[2] = '{A_SHOT, 32'd0};
    rd_tbl[3] = '{A_STAT, 32'd0};
    rd_tbl[4] = '{A_SEED, 32'd0};
    rd_tbl[5] = '{4'd15,  32'd0};

    seed_tbl[0] = '{32'd5,   32'h8000_0006, 32'h0000_0100};
    seed_tbl[1] = '{32'd0,   32'h8000_0002, 32'h0000_0100};
    seed_tbl[2] = '{32'd127, 32'h8000_0208, 32'h0000_0100};
    seed_tbl[3] = '{32'd99,  32'h8000_0909, 32'h0000_0100};
    seed_tbl[4] = '{32'd100, 32'h8000_0000, 32'h0000_0100};
    seed_tbl[5] = '{32'd109, 32'h8000_0101, 32'h0000_0100};
    seed_tbl[6] = '{32'd131, 32'h8000_0004, 32'h0000_0100};

    // Reset and INIT sweep
    addr = A_SHOT; read_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("reset_wait", {31'd0, wait_request}, 32'd1);
    check("reset_data", data_out, 32'd0);
    @(negedge clock);
    read_en = 1'b0;
    reset_n = 1'b1;
    model_newgame();
    model_seed(1);
    n = 0;
    #1;
    while (wait_request && n < 300) begin
      n++;
      @(negedge clock); #1;
    end
    check("init_cycles", n, 100);
    repeat (3) @(negedge clock);
    #1;
    check("idle_wait", {31'd0, wait_request}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      bus_read(rd_tbl[i].a, d, st);
      check($sformatf("reset_reg%0d", rd_tbl[i].a), d, rd_tbl[i].exp);
    end

    for (int i = 0; i < 7; i++) begin
      new_game();
      bus_write(A_SEED, seed_tbl[i].seed);
      bus_write(A_CTRL, 32'd1);
      bus_read(A_SHOT, d, st);
      check($sformatf("seed_shot%0d", i), d, seed_tbl[i].shot);
      bus_read(A_STAT, d, st);
      check($sformatf("seed_status%0d", i), d, seed_tbl[i].status);
    end

    // Directed hunt/target sequence
    new_game();
    bus_write(A_SEED, 32'd5); model_seed(5);
    do_start_and_check("seq_first");
    bus_read(A_SHOT, d, st);
    check("seq_first_lit", d, 32'h8000_0006);
    bus_write(A_RES, 32'd1); model_result(1);
    do_start_and_check("seq_hit");
    bus_read(A_STAT, d, st);
    check("seq_hit_status", d, exp_status());
`ifdef AI_TARGET_EN
    bus_read(A_SHOT, d, st);
    check("seq_east_lit", d, 32'h8000_0007);
    check("seq_mode_lit", {31'd0, exp_status()[1]}, 32'd1);
`endif
    bus_write(A_RES, 32'd0); model_result(0);
    bus_write(A_CTRL, 32'd1); model_start();
    bus_read(A_SHOT, d, st);
    check("seq_miss", d, exp_shot());
    check("seq_stall", {31'd0, st >= 1}, 32'd1);
`ifdef AI_TARGET_EN
    check("seq_south_lit", d, 32'h8000_0106);
`endif
    bus_write(A_RES, 32'd2); model_result(2);
    do_start_and_check("seq_sunk");
    bus_read(A_SHOT, d, st);
    check("seq_parity", {31'd0, d[0] ^ d[8]}, 32'd0);
    bus_read(A_STAT, d, st);
    check("seq_status4", d, 32'h0000_0400);

    // Fill the board, then one more start must report full
    new_game();
    r = $urandom_range(0, 127);
    bus_write(A_SEED, r); model_seed(r);
    for (int i = 0; i < 100; i++) do_start_and_check($sformatf("fill%0d", i));
    bus_read(A_SHOT, d, st);
    check("fill_last_valid", {31'd0, d[31]}, 32'd1);
    bus_write(A_CTRL, 32'd1); model_start();
    bus_read(A_SHOT, d, st);
    check("full_valid", {31'd0, d[31]}, 32'd0);
    check("full_shot_model", d, exp_shot());
    bus_read(A_STAT, d, st);
    check("full_status", d & 32'h0000_7F04, 32'h0000_6404);
    new_game();
    bus_read(A_STAT, d, st);
    check("newgame_status", d, 32'd0);
    check("newgame_stall", {31'd0, st >= 90}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (m_count >= 90) new_game();
      if (r <= 4) begin
        do_start_and_check($sformatf("rnd_shot%0d", i));
      end else if (r <= 6) begin
        int code;
        code = $urandom_range(0, 3);
        bus_write(A_RES, code); model_result(code);
      end else if (r == 7) begin
        bus_read(A_STAT, d, st);
        check($sformatf("rnd_status%0d", i), d, exp_status());
      end else if (r == 8) begin
        d = $urandom;
        bus_write(A_SEED, d); model_seed(int'(d[6:0]));
      end else begin
        logic [3:0] a;
        a = 4'($urandom_range(5, 15));
        bus_write(a, $urandom);
        bus_read(a, d, st);
        check($sformatf("rnd_unmapped%0d", i), d, 32'd0);
      end
    end
    bus_read(A_STAT, d, st);
    check("final_status", d, exp_status());
    bus_read(A_SHOT, d, st);
    check("final_shot", d, exp_shot());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
